multicycle_control_fsm: RTL and testbench

//  Multicycle main controller of the 16-bit CPU. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK from the IR opcode.

---
 rtl/cpu16_pkg.sv | 77 +++++++
 rtl/multicycle_control_fsm.sv | 150 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit multicycle CPU: opcodes, ALUOp codes, mux selects,
// controller state encodings and the control-strobe bundle.
package cpu16_pkg;

  localparam int unsigned OPW    = 4;
  localparam int unsigned STATEW = 4;

  localparam logic [OPW-1:0] OP_R_LOGIC = 4'b0000;
  localparam logic [OPW-1:0] OP_R_ARITH = 4'b0001;
  localparam logic [OPW-1:0] OP_SHIFT   = 4'b0010;
  localparam logic [OPW-1:0] OP_LW      = 4'b0100;
  localparam logic [OPW-1:0] OP_SW      = 4'b0101;
  localparam logic [OPW-1:0] OP_BEQ     = 4'b0110;
  localparam logic [OPW-1:0] OP_JMP     = 4'b0111;
  localparam logic [OPW-1:0] OP_ADDI    = 4'b1001;
  localparam logic [OPW-1:0] OP_SUBI    = 4'b1010;
  localparam logic [OPW-1:0] OP_SLTI    = 4'b1011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_ONE     = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATEW-1:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StWbAlu   = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StWbMem   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Successor of DECODE; StFetch doubles as the illegal-opcode marker.
  function automatic state_e decode_target(input logic [OPW-1:0] op);
    case (op)
      OP_R_LOGIC, OP_R_ARITH:               return StExecR;
      OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI: return StExecI;
      OP_LW, OP_SW:                         return StMemAddr;
      OP_BEQ:                               return StBranch;
      OP_JMP:                               return StJump;
      default:                              return StFetch;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback from the opcode
// and drives the datapath strobes, stalling on the memory ready handshake.
module multicycle_control_fsm
  import cpu16_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  input  logic           mem_ready_i,
  output logic           pc_write_o,
  output logic           pc_write_cond_o,
  output logic           ior_d_o,
  output logic           mem_read_o,
  output logic           mem_write_o,
  output logic           ir_write_o,
  output logic           mem_to_reg_o,
  output logic           reg_dst_o,
  output logic           reg_write_o,
  output logic           alu_src_a_o,
  output logic [1:0]     alu_src_b_o,
  output logic [1:0]     pc_source_o,
  output logic [1:0]     alu_op_o,
  output logic           instr_done_o,
  output logic           illegal_op_o
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  ctrl_t          ctrl, ctrl_out;

  // The branch decision is taken in the datapath via pc_write_cond; the flag is not needed here.
  logic unused_zero;
  assign unused_zero = zero_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    op_d    = op_q;
    case (state_q)
      StFetch:  state_d = mem_ready_i ? StDecode : StFetch;
      StDecode: begin
        state_d = decode_target(opcode_i);
        op_d    = opcode_i;
      end
      StExecR, StExecI: state_d = StWbAlu;
      StMemAddr:        state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
      StMemRd:          state_d = mem_ready_i ? StWbMem : StMemRd;
      StMemWr:          state_d = mem_ready_i ? StFetch : StMemWr;
      default:          state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl.alu_src_b  = SRCB_IMM_SHL;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (decode_target(opcode_i) == StFetch);
        ctrl.instr_done = (decode_target(opcode_i) == StFetch);
      end
      StExecR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      StExecI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
      end
      StWbAlu: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op_q == OP_R_LOGIC) || (op_q == OP_R_ARITH);
        ctrl.instr_done = 1'b1;
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl.ior_d    = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      StWbMem: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.ior_d      = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready_i;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset forces every strobe low in the same cycle, aborting any access in flight.
  assign ctrl_out = rst_i ? '0 : ctrl;

  assign pc_write_o      = ctrl_out.pc_write;
  assign pc_write_cond_o = ctrl_out.pc_write_cond;
  assign ior_d_o         = ctrl_out.ior_d;
  assign mem_read_o      = ctrl_out.mem_read;
  assign mem_write_o     = ctrl_out.mem_write;
  assign ir_write_o      = ctrl_out.ir_write;
  assign mem_to_reg_o    = ctrl_out.mem_to_reg;
  assign reg_dst_o       = ctrl_out.reg_dst;
  assign reg_write_o     = ctrl_out.reg_write;
  assign alu_src_a_o     = ctrl_out.alu_src_a;
  assign alu_src_b_o     = ctrl_out.alu_src_b;
  assign pc_source_o     = ctrl_out.pc_source;
  assign alu_op_o        = ctrl_out.alu_op;
  assign instr_done_o    = ctrl_out.instr_done;
  assign illegal_op_o    = ctrl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: the driver pushes one hand-computed strobe vector per cycle and the monitor
// compares it against the controller outputs half a cycle later.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } item_t;

  localparam exp_t EZero    = '0;
  localparam exp_t EFWait   = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam exp_t EFRdy    = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1,
                                pc_write: 1'b1, default: '0};
  localparam exp_t EDec     = '{alu_src_b: 2'b11, default: '0};
  localparam exp_t EDecIll  = '{alu_src_b: 2'b11, instr_done: 1'b1, illegal_op: 1'b1,
                                default: '0};
  localparam exp_t EExR     = '{alu_src_a: 1'b1, alu_src_b: 2'b00, alu_op: 2'b10, default: '0};
  localparam exp_t EExI     = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 2'b11, default: '0};
  localparam exp_t EWbR     = '{reg_write: 1'b1, reg_dst: 1'b1, instr_done: 1'b1, default: '0};
  localparam exp_t EWbI     = '{reg_write: 1'b1, instr_done: 1'b1, default: '0};
  localparam exp_t EMAddr   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam exp_t EMRd     = '{ior_d: 1'b1, mem_read: 1'b1, default: '0};
  localparam exp_t EWbM     = '{reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1,
                                default: '0};
  localparam exp_t EMWrWait = '{ior_d: 1'b1, mem_write: 1'b1, default: '0};
  localparam exp_t EMWrRdy  = '{ior_d: 1'b1, mem_write: 1'b1, instr_done: 1'b1, default: '0};
  localparam exp_t EBr      = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1,
                                pc_source: 2'b01, instr_done: 1'b1, default: '0};
  localparam exp_t EJmp     = '{pc_write: 1'b1, pc_source: 2'b10, instr_done: 1'b1,
                                default: '0};

  logic       clk, rst, zero, mem_ready;
  logic [3:0] opcode;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source, alu_op;
  exp_t       act;

  item_t      sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  multicycle_control_fsm dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .opcode_i        (opcode),
    .zero_i          (zero),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .ior_d_o         (ior_d),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .pc_source_o     (pc_source),
    .alu_op_o        (alu_op),
    .instr_done_o    (instr_done),
    .illegal_op_o    (illegal_op)
  );

  assign act = '{pc_write: pc_write, pc_write_cond: pc_write_cond, ior_d: ior_d,
                 mem_read: mem_read, mem_write: mem_write, ir_write: ir_write,
                 mem_to_reg: mem_to_reg, reg_dst: reg_dst, reg_write: reg_write,
                 alu_src_a: alu_src_a, alu_src_b: alu_src_b, pc_source: pc_source,
                 alu_op: alu_op, instr_done: instr_done, illegal_op: illegal_op};

  // Starting high puts a falling edge before the first rising edge, so each cycle's vector
  // is checked while the state it describes is still current.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      it = sb_q.pop_front();
      n_vec++;
      if (act !== it.e) begin
        n_err++;
        $display("FAIL %s: got %b want %b", it.name, act, it.e);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                      input exp_t e, input string name);
    item_t it;
    rst       = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    it.e      = e;
    it.name   = name;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with memory ready: nothing may strobe.
    step(1, 4'b0000, 0, 1, EZero, "reset_c1");
    step(1, 4'b0000, 0, 1, EZero, "reset_c2");

    // ADD/SUB R-type, 4 cycles.
    step(0, 4'b0001, 0, 1, EFRdy, "r_fetch");
    step(0, 4'b0001, 0, 1, EDec,  "r_decode");
    step(0, 4'b0001, 0, 1, EExR,  "r_exec");
    step(0, 4'b0001, 0, 1, EWbR,  "r_wb");

    // LW with three MEM_RD wait cycles; opcode changes after DECODE must be ignored.
    step(0, 4'b0100, 0, 1, EFRdy,  "lw_fetch");
    step(0, 4'b0100, 0, 1, EDec,   "lw_decode");
    step(0, 4'b0101, 0, 1, EMAddr, "lw_addr");
    step(0, 4'b0101, 0, 0, EMRd,   "lw_rd_wait1");
    step(0, 4'b0101, 0, 0, EMRd,   "lw_rd_wait2");
    step(0, 4'b0101, 0, 0, EMRd,   "lw_rd_wait3");
    step(0, 4'b0101, 0, 1, EMRd,   "lw_rd_ready");
    step(0, 4'b0101, 0, 1, EWbM,   "lw_wb");

    // ADDI with two FETCH stall cycles; writes rt (RegDst=0).
    step(0, 4'b1001, 0, 0, EFWait, "addi_fetch_wait1");
    step(0, 4'b1001, 0, 0, EFWait, "addi_fetch_wait2");
    step(0, 4'b1001, 0, 1, EFRdy,  "addi_fetch");
    step(0, 4'b1001, 0, 1, EDec,   "addi_decode");
    step(0, 4'b1001, 0, 1, EExI,   "addi_exec");
    step(0, 4'b1001, 0, 1, EWbI,   "addi_wb");

    // BEQ with Zero=1, 3 cycles.
    step(0, 4'b0110, 1, 1, EFRdy, "beq_fetch");
    step(0, 4'b0110, 1, 1, EDec,  "beq_decode");
    step(0, 4'b0110, 1, 1, EBr,   "beq_branch");

    // JMP, 3 cycles.
    step(0, 4'b0111, 0, 1, EFRdy, "jmp_fetch");
    step(0, 4'b0111, 0, 1, EDec,  "jmp_decode");
    step(0, 4'b0111, 0, 1, EJmp,  "jmp_jump");

    // Illegal opcodes take 2 cycles and fall straight back to FETCH.
    step(0, 4'b1111, 0, 1, EFRdy,   "ill15_fetch");
    step(0, 4'b1111, 0, 1, EDecIll, "ill15_decode");
    step(0, 4'b0011, 0, 1, EFRdy,   "ill3_fetch");
    step(0, 4'b0011, 0, 1, EDecIll, "ill3_decode");
    step(0, 4'b1000, 0, 1, EFRdy,   "ill8_fetch");
    step(0, 4'b1000, 0, 1, EDecIll, "ill8_decode");

    // SW with one MEM_WR wait cycle.
    step(0, 4'b0101, 0, 1, EFRdy,    "sw_fetch");
    step(0, 4'b0101, 0, 1, EDec,     "sw_decode");
    step(0, 4'b0101, 0, 1, EMAddr,   "sw_addr");
    step(0, 4'b0101, 0, 0, EMWrWait, "sw_wr_wait");
    step(0, 4'b0101, 0, 1, EMWrRdy,  "sw_wr_ready");

    // SW aborted by reset while stalled in MEM_WR.
    step(0, 4'b0101, 0, 1, EFRdy,    "swab_fetch");
    step(0, 4'b0101, 0, 1, EDec,     "swab_decode");
    step(0, 4'b0101, 0, 1, EMAddr,   "swab_addr");
    step(0, 4'b0101, 0, 0, EMWrWait, "swab_wr_wait");
    step(1, 4'b0101, 0, 0, EZero,    "swab_reset");

    // Shift after the abort must restart from FETCH.
    step(0, 4'b0010, 0, 1, EFRdy, "shift_fetch");
    step(0, 4'b0010, 0, 1, EDec,  "shift_decode");
    step(0, 4'b0010, 0, 1, EExI,  "shift_exec");
    step(0, 4'b0010, 0, 1, EWbI,  "shift_wb");

    // SLTI then AND/OR/XOR R-type back to back.
    step(0, 4'b1011, 0, 1, EFRdy, "slti_fetch");
    step(0, 4'b1011, 0, 1, EDec,  "slti_decode");
    step(0, 4'b1011, 0, 1, EExI,  "slti_exec");
    step(0, 4'b1011, 0, 1, EWbI,  "slti_wb");
    step(0, 4'b0000, 0, 1, EFRdy, "rl_fetch");
    step(0, 4'b0000, 0, 1, EDec,  "rl_decode");
    step(0, 4'b0000, 0, 1, EExR,  "rl_exec");
    step(0, 4'b0000, 0, 1, EWbR,  "rl_wb");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending vectors want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
